// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer
//
// Performs a W-bit add with carry-in (W = 4*NIBBLES) on an external 4-bit
// registered adder, one nibble at a time with the carry chained through an
// internal register. Each nibble takes two cycles: ISSUE presents the
// operands, WAIT captures the adder's registered result one cycle later.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is high only in IDLE. res_valid is high only in
// DONE, where result/c_out are held until res_ready is seen.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake; op_a, op_b, c_in sampled on it
//   res_valid/res_ready response handshake; result, c_out returned
//   busy                high while a nibble is being issued or awaited
//   done_cnt            completed response handshakes, wraps 255 -> 0
//   add_a/add_b/add_cin operands to the shared adder (zero outside ISSUE)
//   add_sum/add_cout    registered adder outputs, sampled only in WAIT
//   fsm_state           debug view of the state register
module nibble_add_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   c_in,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   c_out,
    output logic                   busy,
    output logic [7:0]             done_cnt,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout,
    output logic [1:0]             fsm_state
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_lat;
    logic [W-1:0]  b_lat;
    logic [3:0]    nib_a;
    logic [3:0]    nib_b;

    // Select the current operand nibbles with constant part-selects so the
    // mux stays a plain decode of idx.
    always_comb begin
        nib_a = 4'd0;
        nib_b = 4'd0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (idx == IW'(k)) begin
                nib_a = a_lat[4*k +: 4];
                nib_b = b_lat[4*k +: 4];
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign res_valid = (state == DONE);
    assign busy      = (state == ISSUE) || (state == WAIT);
    assign fsm_state = state;

    // The adder sees zeros outside ISSUE so its inputs are quiet and
    // predictable whenever no nibble is in flight.
    assign add_a   = (state == ISSUE) ? nib_a : 4'd0;
    assign add_b   = (state == ISSUE) ? nib_b : 4'd0;
    assign add_cin = (state == ISSUE) ? carry : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            a_lat    <= '0;
            b_lat    <= '0;
            result   <= '0;
            c_out    <= 1'b0;
            done_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_lat <= op_a;
                        b_lat <= op_b;
                        carry <= c_in;
                        idx   <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // Adder output now reflects the operands issued last cycle.
                    for (int k = 0; k < NIBBLES; k++) begin
                        if (idx == IW'(k)) begin
                            result[4*k +: 4] <= add_sum;
                        end
                    end
                    carry <= add_cout;
                    if (idx == LAST_IDX) begin
                        c_out <= add_cout;
                        state <= DONE;
                    end else begin
                        idx   <= idx + IW'(1);
                        state <= ISSUE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        done_cnt <= done_cnt + 8'd1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/nibble_add_sequencer.md
# nibble_add_sequencer

Sequencer that performs a 4·NIBBLES-bit add with carry-in on the team's shared 4-bit registered adder, one nibble at a time with carry chaining. It accepts wide operands over a valid/ready request port and drives the adder's A/B/C_in inputs. It captures SUM/C_out nibble by nibble and returns the wide result over a valid/ready response port. It sits between a requesting datapath and a single adder instance, so one small adder serves arbitrary-width additions.

## Interface
- NIBBLES, 4: operand width in nibbles; operand width W = 4·NIBBLES; legal range 2..16.

- Clock  in  1  rising-edge clock for all state.
- Reset_n  in  1  one clock; reset is asynchronous and active-low.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  sequencer can accept a request; equals state==IDLE.
- OP_A  in  W  first operand, sampled on request handshake.
- OP_B  in  W  second operand, sampled on request handshake.
- C_in  in  1  carry-in, sampled on request handshake.
- RES_VALID  out  1  result available.
- RES_READY  in  1  consumer takes result.
- RESULT  out  W  sum bits.
- C_out  out  1  final carry.
- BUSY  out  1  high in ISSUE/WAIT.
- DONE_CNT  out  8  count of completed response handshakes, wraps 255→0.
- ADD_A  out  4  operand nibble to adder.
- ADD_B  out  4  operand nibble to adder.
- ADD_CIN  out  1  carry to adder.
- ADD_SUM  in  4  adder registered sum.
- ADD_COUT  in  1  adder registered carry.

## Operation
- The adder registers its outputs on every rising Clock. ADD_SUM/ADD_COUT reflect the operands presented in the previous cycle. The adder has no reset.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID&REQ_READY, latch OP_A, OP_B, C_in into an internal carry register; clear the index; go to ISSUE.
- ISSUE:
  - ADD_A=A_lat[4·idx+3:4·idx], ADD_B=B_lat nibble idx, ADD_CIN=carry register.
  - Always go to WAIT.
- WAIT:
  - Capture ADD_SUM into RESULT nibble idx; carry register<=ADD_COUT.
  - If idx==NIBBLES-1: C_out<=ADD_COUT, go to DONE.
  - Otherwise idx<=idx+1, go to ISSUE.
- DONE:
  - RES_VALID=1; RESULT and C_out held stable.
  - On RES_READY, go to IDLE and increment DONE_CNT.
  - No request is accepted in DONE (REQ_READY=0).
- ADD_A/ADD_B/ADD_CIN are 0 in every state except ISSUE.
- ADD_SUM/ADD_COUT are sampled only in WAIT; stale adder output at any other time is ignored.
- RESULT nibbles not yet written in the current operation keep their previous value. Only RESULT in DONE is defined.
- Arithmetic: {C_out,RESULT} = OP_A + OP_B + C_in, exact at W+1 bits; no overflow flag.
- REQ_VALID while not in IDLE is ignored. OP_A/OP_B changes after the handshake have no effect.

## Timing
- Reset (Reset_n low, asynchronous):
  - State=IDLE; idx, carry register, latched operands, RESULT, C_out, DONE_CNT = 0.
  - RES_VALID=0, BUSY=0, REQ_READY=1, ADD_*=0.
- Latency:
  - Request handshake at edge E0 gives RES_VALID=1 after edge E0+2·NIBBLES (8 cycles for NIBBLES=4).
  - Nibble k is presented during cycle 2k+1 after E0 and captured at edge E0+2k+2.
- Throughput: one operation per 2·NIBBLES+2 cycles with RES_READY held high (response handshake cycle plus one IDLE cycle).
- Response handshake at edge E gives RES_VALID=0 and REQ_READY=1 in the next cycle; the next request can be accepted at edge E+1.
- Reset mid-operation:
  - Aborts immediately; no response is produced and DONE_CNT is unchanged.
  - The first request after release produces a result with no carry residue from the aborted operation.
- DONE_CNT increments exactly once per response handshake; 255+1 wraps to 0.

## Test plan
- Reset with Clock running, Reset_n low 3 cycles: every output at its reset value while low. REQ_READY=1 after release.
- 0x1234+0x1111, C_in=0: RESULT=0x2345, C_out=0, RES_VALID exactly 8 cycles after the request handshake. ADD_A/ADD_B sequence 4/1, 3/1, 2/1, 1/1 in ISSUE cycles, 0 elsewhere.
- 0xFFFF+0x0000, C_in=1: RESULT=0x0000, C_out=1; carry propagates through all four nibbles (ADD_CIN=1 in every ISSUE cycle).
- 0x8000+0x8000, C_in=0, RES_READY low 5 cycles in DONE: RESULT=0x0000, C_out=1 held stable and REQ_READY=0 throughout. A REQ_VALID pulse during DONE is ignored. After RES_READY, IDLE next cycle and DONE_CNT=1.
- Reset_n pulsed low during WAIT of nibble 2 of 0xFFFF+0x0001: outputs reset asynchronously, DONE_CNT=0. Then 0x0001+0x0001, C_in=0: RESULT=0x0002, C_out=0.
- 256 back-to-back random operations with RES_READY=1: each result matches the reference sum, DONE_CNT wraps to 0 after the 256th, and the spacing between request handshakes is 10 cycles.
